// File: rtl/option22_pkg.sv
// Shared op-codes, FSM states and defaults for the option22 ring-memory host.
package option22_pkg;

    localparam int WORD_COUNT_DEF = 64;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INIT  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IDLE = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_LOF  = 3'd4,
        ST_RESP = 3'd5
    } state_e;

endpackage

// File: rtl/option22_phase_div.sv
// Counts CLK_DIV host cycles per chip half-period; restarts whenever the FSM changes state.
module option22_phase_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic phase_done_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign phase_done_o = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || phase_done_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/option22_host.sv
// Host driver for the option22 serial ring memory: bit-bangs one byte per command
// over the chip pins and returns the byte the chip presents after the 8th clock.
module option22_host
    import option22_pkg::*;
#(
    parameter int WORD_COUNT = WORD_COUNT_DEF,
    parameter int CLK_DIV    = 1,
    parameter int RST_HALVES = 2,
    localparam int PW        = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic [PW-1:0] rsp_ptr,
    output logic          chip_clk,
    output logic          chip_reset,
    output logic          chip_write,
    output logic          chip_din,
    input  logic [7:0]    chip_dout
);

    localparam int HW = $clog2(RST_HALVES + 1);

    state_e        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q, wr_d;
    logic [2:0]    bit_q, bit_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] halves_q, halves_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic [PW-1:0] rsp_ptr_q, rsp_ptr_d;
    logic          phase_done;

    option22_phase_div #(.CLK_DIV(CLK_DIV)) u_phase_div (
        .clk          (clk),
        .reset        (reset),
        .restart_i    (state_d != state_q),
        .phase_done_o (phase_done)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        wr_d       = wr_q;
        bit_d      = bit_q;
        ptr_d      = ptr_q;
        halves_d   = halves_q;
        rsp_data_d = rsp_data_q;
        rsp_ptr_d  = rsp_ptr_q;
        case (state_q)
            ST_RST: begin
                if (phase_done) begin
                    if (halves_q == HW'(RST_HALVES - 1)) begin
                        halves_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        halves_d = halves_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_READ, OP_WRITE: begin
                            wr_d    = (cmd_op == OP_WRITE);
                            data_d  = cmd_data;
                            bit_d   = 3'd7;
                            state_d = ST_LO;
                        end
                        OP_INIT: begin
                            ptr_d    = '0;
                            halves_d = '0;
                            state_d  = ST_RST;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LO: if (phase_done) state_d = ST_HI;
            ST_HI: begin
                if (phase_done) begin
                    if (bit_q == 3'd0) begin
                        state_d = ST_LOF;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LOF: begin
                // The chip has taken its 8th rising edge; its output is settled by now.
                if (phase_done) begin
                    rsp_data_d = chip_dout;
                    rsp_ptr_d  = ptr_q;
                    ptr_d      = (ptr_q == PW'(WORD_COUNT - 1)) ? '0 : ptr_q + 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RST;
            data_q     <= '0;
            wr_q       <= 1'b0;
            bit_q      <= '0;
            ptr_q      <= '0;
            halves_q   <= '0;
            rsp_data_q <= '0;
            rsp_ptr_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            bit_q      <= bit_d;
            ptr_q      <= ptr_d;
            halves_q   <= halves_d;
            rsp_data_q <= rsp_data_d;
            rsp_ptr_q  <= rsp_ptr_d;
        end
    end

    // Write/din stay valid through HI so the chip sees them held past its rising edge.
    assign chip_clk   = (state_q == ST_HI);
    assign chip_reset = (state_q == ST_RST);
    assign chip_write = wr_q && ((state_q == ST_LO) || (state_q == ST_HI));
    assign chip_din   = chip_write && data_q[bit_q];
    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_ptr    = rsp_ptr_q;

endmodule
